// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//   Hazard and forwarding controller for a 5-stage MIPS pipeline.
//   - Stalls PC/IF-ID and bubbles ID/EX on load-use hazards, on branch-in-ID
//     operand hazards, and on HI/LO readers while the mult/div unit is busy.
//   - Flushes IF/ID on a taken branch or jump that is not itself stalled.
//   - Selects EX-stage operand forwarding from MEM (priority) or WB.
//   - Tracks the multi-cycle mult/div unit with a two-state busy FSM.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_jump, i_branch_id,
//   i_branch_taken               control-flow info for the instruction in ID
//   i_rs_id, i_rt_id             source registers in ID
//   i_rs_ex, i_rt_ex, i_wr_ex    source/destination registers in EX
//   i_reg_write_ex,
//   i_mem_read_ex                EX writes regfile / EX is a load
//   i_wr_mem, i_reg_write_mem,
//   i_mem_read_mem               MEM destination / writes regfile / is a load
//   i_wr_wb, i_reg_write_wb      WB destination / writes regfile
//   i_md_start_ex                mult/div start pulse from EX
//   i_hilo_use_id                ID instruction touches HI/LO
//   o_stall, o_bubble, o_flush   pipeline control
//   o_fwd_a, o_fwd_b             forwarding selects: 00 regfile, 10 MEM, 01 WB
//   o_md_busy                    mult/div in progress (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int NB_REG     = 5,
  parameter int MD_LATENCY = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_jump,
  input  logic              i_branch_id,
  input  logic              i_branch_taken,
  input  logic [NB_REG-1:0] i_rs_id,
  input  logic [NB_REG-1:0] i_rt_id,
  input  logic [NB_REG-1:0] i_rs_ex,
  input  logic [NB_REG-1:0] i_rt_ex,
  input  logic [NB_REG-1:0] i_wr_ex,
  input  logic              i_reg_write_ex,
  input  logic              i_mem_read_ex,
  input  logic [NB_REG-1:0] i_wr_mem,
  input  logic              i_reg_write_mem,
  input  logic              i_mem_read_mem,
  input  logic [NB_REG-1:0] i_wr_wb,
  input  logic              i_reg_write_wb,
  input  logic              i_md_start_ex,
  input  logic              i_hilo_use_id,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_md_busy
);

  localparam int NB_CNT = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e           state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;

  // Register 0 is hardwired to zero, so it never matches as a producer.
  function automatic logic reg_hit(input logic [NB_REG-1:0] dst,
                                   input logic [NB_REG-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [NB_REG-1:0] src);
    if (i_reg_write_mem && reg_hit(i_wr_mem, src))     return 2'b10;
    else if (i_reg_write_wb && reg_hit(i_wr_wb, src))  return 2'b01;
    else                                               return 2'b00;
  endfunction

  // ---------------------------------------------------------------------------
  // Mult/div busy FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter is loaded with MD_LATENCY-1 because the
  // start cycle itself already counts toward the latency.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (i_md_start_ex) begin
          state_d = MD_BUSY;
          cnt_d   = NB_CNT'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q == NB_CNT'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - NB_CNT'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_md_busy = (state_q == MD_BUSY);
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and forwarding
  // ---------------------------------------------------------------------------
  logic load_use, br_hz, md_hz, hazard;

  always_comb begin
    load_use = i_mem_read_ex && (reg_hit(i_wr_ex, i_rs_id) || reg_hit(i_wr_ex, i_rt_id));

    // A branch compares in ID, so it must wait for an ALU result still in EX
    // or for load data still in MEM.
    br_hz = i_branch_id &&
            ((i_reg_write_ex && (reg_hit(i_wr_ex, i_rs_id)  || reg_hit(i_wr_ex, i_rt_id))) ||
             (i_mem_read_mem && (reg_hit(i_wr_mem, i_rs_id) || reg_hit(i_wr_mem, i_rt_id))));

    // The start cycle itself is covered by i_md_start_ex, before busy rises.
    md_hz  = i_hilo_use_id && (o_md_busy || i_md_start_ex);
    hazard = load_use || br_hz || md_hz;

    o_stall  = 1'b0;
    o_bubble = 1'b0;
    o_flush  = 1'b0;
    o_fwd_a  = 2'b00;
    o_fwd_b  = 2'b00;
    if (!i_rst) begin
      o_stall  = hazard;
      o_bubble = hazard;
      // A stalled branch/jump re-resolves next cycle, so it must not flush yet.
      o_flush  = (i_jump || i_branch_taken) && !hazard;
      o_fwd_a  = fwd_sel(i_rs_ex);
      o_fwd_b  = fwd_sel(i_rt_ex);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model: hazards are evaluated from the register
//   matching rules, and mult/div occupancy is derived from the cycle number at
//   which the accepted operation started.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  localparam int NB_REG     = 5;
  localparam int MD_LATENCY = 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_jump, i_branch_id, i_branch_taken;
  logic [NB_REG-1:0] i_rs_id, i_rt_id, i_rs_ex, i_rt_ex, i_wr_ex, i_wr_mem, i_wr_wb;
  logic              i_reg_write_ex, i_mem_read_ex;
  logic              i_reg_write_mem, i_mem_read_mem, i_reg_write_wb;
  logic              i_md_start_ex, i_hilo_use_id;
  logic              o_stall, o_bubble, o_flush, o_md_busy;
  logic [1:0]        o_fwd_a, o_fwd_b;

  hazard_ctrl_unit #(.NB_REG(NB_REG), .MD_LATENCY(MD_LATENCY)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_jump         (i_jump),
    .i_branch_id    (i_branch_id),
    .i_branch_taken (i_branch_taken),
    .i_rs_id        (i_rs_id),
    .i_rt_id        (i_rt_id),
    .i_rs_ex        (i_rs_ex),
    .i_rt_ex        (i_rt_ex),
    .i_wr_ex        (i_wr_ex),
    .i_reg_write_ex (i_reg_write_ex),
    .i_mem_read_ex  (i_mem_read_ex),
    .i_wr_mem       (i_wr_mem),
    .i_reg_write_mem(i_reg_write_mem),
    .i_mem_read_mem (i_mem_read_mem),
    .i_wr_wb        (i_wr_wb),
    .i_reg_write_wb (i_reg_write_wb),
    .i_md_start_ex  (i_md_start_ex),
    .i_hilo_use_id  (i_hilo_use_id),
    .o_stall        (o_stall),
    .o_bubble       (o_bubble),
    .o_flush        (o_flush),
    .o_fwd_a        (o_fwd_a),
    .o_fwd_b        (o_fwd_b),
    .o_md_busy      (o_md_busy)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Model state: current cycle number and the cycle an accepted mult/div began.
  int cyc          = 0;
  int md_start_cyc = -1000;

  logic last_stall, last_busy;

  function automatic logic model_busy();
    return (cyc > md_start_cyc) && (cyc < md_start_cyc + MD_LATENCY);
  endfunction

  function automatic logic dep(input logic [NB_REG-1:0] d, input logic [NB_REG-1:0] s);
    return (d != 0) && (d == s);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
  endtask

  task automatic drive_idle();
    i_rst = 1'b0; i_jump = 1'b0; i_branch_id = 1'b0; i_branch_taken = 1'b0;
    i_rs_id = '0; i_rt_id = '0; i_rs_ex = '0; i_rt_ex = '0;
    i_wr_ex = '0; i_wr_mem = '0; i_wr_wb = '0;
    i_reg_write_ex = 1'b0; i_mem_read_ex = 1'b0;
    i_reg_write_mem = 1'b0; i_mem_read_mem = 1'b0; i_reg_write_wb = 1'b0;
    i_md_start_ex = 1'b0; i_hilo_use_id = 1'b0;
  endtask

  // Inputs are already applied; compare all outputs to the model, then
  // advance one clock and update the model's mult/div occupancy.
  task automatic step(input string tag);
    logic       hz, e_flush;
    logic [1:0] e_a, e_b;
    logic       busy;
    #1;
    busy = model_busy();
    hz = (i_mem_read_ex && (dep(i_wr_ex, i_rs_id) || dep(i_wr_ex, i_rt_id))) ||
         (i_branch_id && i_reg_write_ex && (dep(i_wr_ex, i_rs_id) || dep(i_wr_ex, i_rt_id))) ||
         (i_branch_id && i_mem_read_mem && (dep(i_wr_mem, i_rs_id) || dep(i_wr_mem, i_rt_id))) ||
         (i_hilo_use_id && (busy || i_md_start_ex));
    e_flush = (i_jump || i_branch_taken) && !hz;
    e_a = (i_reg_write_mem && dep(i_wr_mem, i_rs_ex)) ? 2'b10 :
          (i_reg_write_wb  && dep(i_wr_wb,  i_rs_ex)) ? 2'b01 : 2'b00;
    e_b = (i_reg_write_mem && dep(i_wr_mem, i_rt_ex)) ? 2'b10 :
          (i_reg_write_wb  && dep(i_wr_wb,  i_rt_ex)) ? 2'b01 : 2'b00;
    if (i_rst) begin
      hz = 1'b0; e_flush = 1'b0; e_a = 2'b00; e_b = 2'b00;
    end
    check({tag, ".stall"},   8'(o_stall),   8'(hz));
    check({tag, ".bubble"},  8'(o_bubble),  8'(hz));
    check({tag, ".flush"},   8'(o_flush),   8'(e_flush));
    check({tag, ".fwd_a"},   8'(o_fwd_a),   8'(e_a));
    check({tag, ".fwd_b"},   8'(o_fwd_b),   8'(e_b));
    check({tag, ".md_busy"}, 8'(o_md_busy), 8'(busy));
    last_stall = o_stall;
    last_busy  = o_md_busy;
    @(posedge i_clk);
    if (i_rst)                        md_start_cyc = -1000;
    else if (i_md_start_ex && !busy)  md_start_cyc = cyc;
    cyc++;
    #1;
  endtask

  initial begin
    int n_stall, n_busy;

    // Reset, with inputs that would otherwise cause a stall, flush and forward.
    drive_idle();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_jump = 1'b1; i_mem_read_ex = 1'b1; i_wr_ex = 5'd4; i_rs_id = 5'd4;
    i_reg_write_mem = 1'b1; i_wr_mem = 5'd2; i_rs_ex = 5'd2;
    step("reset");
    check("reset.stall_zero", 8'(last_stall), 8'd0);
    check("reset.busy_zero",  8'(last_busy),  8'd0);

    // Load-use hazard, then the same producer as register 0.
    drive_idle();
    i_mem_read_ex = 1'b1; i_wr_ex = 5'd5; i_rs_id = 5'd5;
    step("load_use");
    check("load_use.stall_hi", 8'(last_stall), 8'd1);
    i_wr_ex = 5'd0; i_rs_id = 5'd0;
    step("load_use_r0");
    check("load_use_r0.stall_lo", 8'(last_stall), 8'd0);
    drive_idle();
    step("load_gone");

    // Forwarding priority: MEM over WB, then WB alone, then on operand B.
    i_reg_write_mem = 1'b1; i_wr_mem = 5'd3; i_reg_write_wb = 1'b1; i_wr_wb = 5'd3;
    i_rs_ex = 5'd3;
    step("fwd_mem");
    i_reg_write_mem = 1'b0;
    step("fwd_wb");
    i_rt_ex = 5'd3; i_rs_ex = 5'd9;
    step("fwd_b_wb");
    drive_idle();

    // Branch in ID depending on EX result, then resolved next cycle.
    i_branch_id = 1'b1; i_branch_taken = 1'b1; i_reg_write_ex = 1'b1;
    i_wr_ex = 5'd7; i_rt_id = 5'd7;
    step("branch_dep");
    check("branch_dep.stall_hi", 8'(last_stall), 8'd1);
    i_reg_write_ex = 1'b0;
    step("branch_free");
    i_mem_read_mem = 1'b1; i_wr_mem = 5'd6; i_rs_id = 5'd6;
    step("branch_load_mem");
    drive_idle();

    // Mult/div: start pulse with a HI/LO reader held in ID.
    n_stall = 0; n_busy = 0;
    i_hilo_use_id = 1'b1; i_md_start_ex = 1'b1;
    step("md_start");
    n_stall += int'(last_stall); n_busy += int'(last_busy);
    i_md_start_ex = 1'b0;
    for (int k = 0; k < 11; k++) begin
      step("md_run");
      n_stall += int'(last_stall); n_busy += int'(last_busy);
    end
    check("md.stall_cycles", 8'(n_stall), 8'(MD_LATENCY));
    check("md.busy_cycles",  8'(n_busy),  8'(MD_LATENCY - 1));

    // Reset during the third busy cycle aborts the operation.
    i_md_start_ex = 1'b1;
    step("md2_start");
    i_md_start_ex = 1'b0;
    step("md2_busy1");
    step("md2_busy2");
    i_rst = 1'b1;
    step("md2_busy3_rst");
    i_rst = 1'b0;
    step("md2_after_rst");
    check("md2.busy_cleared",  8'(last_busy),  8'd0);
    check("md2.stall_cleared", 8'(last_stall), 8'd0);
    drive_idle();

    // Jump with and without a load-use hazard.
    i_jump = 1'b1;
    step("jump_free");
    i_mem_read_ex = 1'b1; i_wr_ex = 5'd8; i_rt_id = 5'd8;
    step("jump_stalled");
    drive_idle();
    step("quiet");

    // Randomized traffic over a small register range so matches are frequent.
    for (int k = 0; k < 400; k++) begin
      i_rst           = ($urandom_range(39) == 0);
      i_jump          = ($urandom_range(4) == 0);
      i_branch_id     = $urandom_range(1) == 1;
      i_branch_taken  = i_branch_id && ($urandom_range(1) == 1);
      i_rs_id         = NB_REG'($urandom_range(3));
      i_rt_id         = NB_REG'($urandom_range(3));
      i_rs_ex         = NB_REG'($urandom_range(3));
      i_rt_ex         = NB_REG'($urandom_range(3));
      i_wr_ex         = NB_REG'($urandom_range(3));
      i_wr_mem        = NB_REG'($urandom_range(3));
      i_wr_wb         = NB_REG'($urandom_range(3));
      i_reg_write_ex  = $urandom_range(1) == 1;
      i_mem_read_ex   = ($urandom_range(3) == 0);
      i_reg_write_mem = $urandom_range(1) == 1;
      i_mem_read_mem  = ($urandom_range(3) == 0);
      i_reg_write_wb  = $urandom_range(1) == 1;
      i_md_start_ex   = ($urandom_range(9) == 0);
      i_hilo_use_id   = ($urandom_range(2) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
